// File: rtl/mem_array_pkg.sv
// mem_array_pkg: shared sizes and clear-FSM state type for the write-side storage bank
package mem_array_pkg;
  localparam int ADDRESS = 10;
  localparam int M = 2**ADDRESS;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/mem_array_wr_n_dec.sv
// dec_n: address to one-hot decoder gated by an enable
module dec_n #(
  parameter int address = 10
) (
  input  logic                  en,
  input  logic [address-1:0]    addr,
  output logic [2**address-1:0] y
);
  localparam int m = 2**address;
  assign y = {{(m-1){1'b0}}, en} << addr;
endmodule

// File: rtl/mux2to1_n.sv
// mux2to1_n: n-bit 2:1 select, b when sel is high
module mux2to1_n #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sel,
  output logic [n-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mem_array_wr_n.sv
// mem_array_wr_n: word storage bank with handshaked write port and a one-word-per-cycle clear sweep
module mem_array_wr_n
  import mem_array_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = ADDRESS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [address-1:0] wr_addr_i,
  input  logic [n-1:0]       wr_data_i,
  input  logic               clr_i,
  output logic               busy_o,
  output logic               clr_done_o,
  output logic [n-1:0]       data_o [0:2**address-1]
);
  localparam int m = 2**address;
  clr_state_t state, nxt;
  logic [address-1:0] ptr, waddr;
  logic [n-1:0] wdata;
  logic [m-1:0] we;
  logic hs;
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (clr_i ? CLEAR : IDLE) : (ptr == '1 ? IDLE : CLEAR);
  end
  always_comb begin
    wr_ready_o = state == IDLE;
    busy_o     = state == CLEAR;
    clr_done_o = state == CLEAR && ptr == '1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) ptr <= '0;
    else ptr <= ptr + 1'b1;
  end
  assign hs = wr_valid_i && wr_ready_o;
  mux2to1_n #(.n(address)) u_addr_mux (.a(wr_addr_i), .b(ptr), .sel(busy_o), .y(waddr));
  mux2to1_n #(.n(n)) u_data_mux (.a(wr_data_i), .b('0), .sel(busy_o), .y(wdata));
  dec_n #(.address(address)) u_dec (.en(hs | busy_o), .addr(waddr), .y(we));
  for (genvar k = 0; k < m; k++) begin : g_word
    always_ff @(posedge clk_i) begin
      if (rst_i) data_o[k] <= '0;
      else if (we[k]) data_o[k] <= wdata;
    end
  end
endmodule

// File: tb/tb_mem_array_wr_n.sv
// tb_mem_array_wr_n: directed scoreboard bench for the storage bank write port and clear sweep
module tb_mem_array_wr_n;
  logic clk = 0;
  logic rst_i, wr_valid_i, clr_i;
  logic wr_ready_o, busy_o, clr_done_o;
  logic [9:0] wr_addr_i;
  logic [3:0] wr_data_i;
  logic [3:0] data_o [0:1023];
  logic [3:0] mdl [0:1023];
  typedef struct {int idx; logic [3:0] val; string tag;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  mem_array_wr_n #(.n(4), .address(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .clr_i(clr_i), .busy_o(busy_o),
    .clr_done_o(clr_done_o), .data_o(data_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(int idx, logic [3:0] val, string tag);
    exp_t e;
    e.idx = idx;
    e.val = val;
    e.tag = tag;
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (data_o[e.idx] === e.val) else begin
        errors++;
        $error("FAIL %s word %0d observed %h expected %h", e.tag, e.idx, data_o[e.idx], e.val);
      end
    end
  endtask
  task automatic check_all(string tag);
    for (int k = 0; k < 1024; k++) push(k, mdl[k], tag);
    drain();
  endtask
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wr(logic [9:0] a, logic [3:0] d);
    wr_valid_i = 1;
    wr_addr_i = a;
    wr_data_i = d;
    step();
    wr_valid_i = 0;
    mdl[a] = d;
  endtask
  initial begin
    int cnt, done_cnt, done_at;
    rst_i = 1;
    wr_valid_i = 0;
    clr_i = 0;
    wr_addr_i = 0;
    wr_data_i = 0;
    for (int k = 0; k < 1024; k++) mdl[k] = 0;
    step();
    step();
    rst_i = 0;
    for (int i = 0; i < 20; i++) wr(10'($urandom_range(1023)), 4'($urandom_range(1, 15)));
    rst_i = 1;
    step();
    rst_i = 0;
    for (int k = 0; k < 1024; k++) mdl[k] = 0;
    check_all("reset_words");
    chk("reset_ready", int'(wr_ready_o), 1);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(clr_done_o), 0);
    wr(10'h3FF, 4'hA);
    push(1023, 4'hA, "single_write");
    push(0, 4'h0, "single_other");
    drain();
    wr(10'd5, 4'h1);
    wr(10'd5, 4'h7);
    wr(10'd6, 4'h2);
    push(5, 4'h7, "b2b_same_addr");
    push(6, 4'h2, "b2b_next_addr");
    drain();
    for (int k = 0; k < 1024; k++) wr(10'(k), 4'hF);
    check_all("full_fill");
    clr_i = 1;
    step();
    clr_i = 0;
    wr_valid_i = 1;
    wr_addr_i = 10'd2;
    wr_data_i = 4'h3;
    chk("clear_ready_low", int'(wr_ready_o), 0);
    cnt = 0;
    done_cnt = 0;
    done_at = 0;
    for (int i = 0; i < 2000 && busy_o; i++) begin
      cnt++;
      if (clr_done_o) begin
        done_cnt++;
        done_at = cnt;
      end
      step();
    end
    wr_valid_i = 0;
    chk("clear_busy_cycles", cnt, 1024);
    chk("clear_done_count", done_cnt, 1);
    chk("clear_done_cycle", done_at, 1024);
    chk("clear_ready_back", int'(wr_ready_o), 1);
    for (int k = 0; k < 1024; k++) mdl[k] = 0;
    check_all("clear_words");
    wr_valid_i = 1;
    wr_addr_i = 10'd0;
    wr_data_i = 4'h5;
    clr_i = 1;
    step();
    wr_valid_i = 0;
    clr_i = 0;
    push(0, 4'h5, "simul_write_commit");
    drain();
    chk("simul_busy", int'(busy_o), 1);
    step();
    push(0, 4'h0, "simul_first_sweep");
    drain();
    for (int i = 0; i < 2000 && busy_o; i++) step();
    chk("simul_sweep_ends", int'(busy_o), 0);
    wr(10'd700, 4'h9);
    wr(10'd1000, 4'h6);
    clr_i = 1;
    step();
    clr_i = 0;
    done_cnt = 0;
    for (int i = 0; i < 299; i++) begin
      if (clr_done_o) done_cnt++;
      step();
    end
    push(700, 4'h9, "mid_clear_untouched");
    push(100, 4'h0, "mid_clear_swept");
    drain();
    chk("mid_clear_busy", int'(busy_o), 1);
    rst_i = 1;
    step();
    rst_i = 0;
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_ready", int'(wr_ready_o), 1);
    if (clr_done_o) done_cnt++;
    for (int k = 0; k < 1024; k++) mdl[k] = 0;
    check_all("rst_mid_words");
    wr(10'd3, 4'hC);
    if (clr_done_o) done_cnt++;
    chk("rst_mid_no_done", done_cnt, 0);
    push(3, 4'hC, "rst_mid_write_after");
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
